mmio_console: RTL and testbench

Memory-mapped console peripheral that sits directly downstream of the pipelined core's data-memory port, alongside `dmem`. Decodes stores on `DataAdr`/`WriteData`/`MemWrite` and queues the low byte of stores to the TX address into a small FIFO. Drains the FIFO over an 8N1 UART transmit line and exposes a status word for polled reads. The top-level selects `ReadData` from this block instead of `dmem` whenever `hit` is high.

---
 rtl/mmio_console_pkg.sv | 20 ++
 rtl/mmio_console_if.sv | 14 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/mmio_console.sv | 140 ++++++++++++++
 tb/tb_mmio_console.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_console_pkg.sv
// Shared definitions for the memory-mapped console: transmitter states,
// core store-strobe encoding and default register addresses.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_B    = 2'b01;
  localparam logic [1:0] MW_H    = 2'b10;
  localparam logic [1:0] MW_W    = 2'b11;

  localparam logic [31:0] CONSOLE_TX_ADDR   = 32'h1000_0000;
  localparam logic [31:0] CONSOLE_STAT_ADDR = 32'h1000_0004;

endpackage

// File: rtl/mmio_console_if.sv
// Core data-memory port as seen by the console: store strobe, address and
// data from the core, status read data and address-hit back to the core.
interface mmio_console_if;
  logic [1:0]  MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (output MemWrite, output DataAdr, output WriteData,
                  input  ReadData, input  hit);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData,
                  output ReadData, output hit);
endinterface

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with combinational read port; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console: queues bytes stored to TX_ADDR and sends them as
// 8N1 UART frames; STAT_ADDR reads back full/busy/ovf and the queue depth.
module mmio_console
  import console_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = CONSOLE_TX_ADDR,
  parameter logic [31:0] STAT_ADDR    = CONSOLE_STAT_ADDR
) (
  input  logic           clk,
  input  logic           rst,
  mmio_console_if.slave  bus,
  output logic           tx
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          ovf_reg;

  logic          tx_sel, stat_sel, tx_push, stat_store, drop, busy, baud_done;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;

  assign tx_sel     = (bus.DataAdr == TX_ADDR);
  assign stat_sel   = (bus.DataAdr == STAT_ADDR);
  assign tx_push    = (bus.MemWrite != MW_NONE) && tx_sel;
  assign stat_store = (bus.MemWrite != MW_NONE) && stat_sel;
  assign drop       = tx_push && fifo_full && !fifo_pop;
  assign busy       = (state_reg != IDLE) || !fifo_empty;

  assign bus.hit      = tx_sel || stat_sel;
  assign bus.ReadData = stat_sel ? {16'h0, 8'(fifo_count), 5'h0, ovf_reg, busy, fifo_full}
                                 : 32'h0;
  assign tx           = tx_reg;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (fifo_pop),
    .din   (bus.WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A same-cycle overflow beats the clearing store.
  always_ff @(posedge clk) begin
    if (rst)             ovf_reg <= 1'b0;
    else if (drop)       ovf_reg <= 1'b1;
    else if (stat_store) ovf_reg <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  assign baud_done = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_dout;
          baud_next  = '0;
          idx_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) state_next = STOP;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is registered from the next state, so it changes on the
  // same edge as the state and never sees the bus inputs combinationally.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: a line monitor decodes every frame and
// checks it bit-for-bit against bytes queued when the stores were driven.
module tb_mmio_console;
  import console_pkg::*;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] TXA   = CONSOLE_TX_ADDR;
  localparam logic [31:0] STA   = CONSOLE_STAT_ADDR;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  mmio_console_if bus();

  mmio_console #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TXA),
    .STAT_ADDR    (STA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          starts[$];
  int          cyc = 0;
  bit          mon_active = 1'b0;
  int          pos = 0;
  logic [40:0] cap;
  logic [7:0]  mon_byte;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit, each CPB cycles, then one idle-high cycle.
  function automatic logic [40:0] frame_bits(input logic [7:0] b);
    logic [9:0]  p;
    logic [40:0] r;
    p = {1'b1, b, 1'b0};
    r = '0;
    for (int c = 0; c < 40; c++) r[c] = p[c / CPB];
    r[40] = 1'b1;
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          cap        = '0;
          pos        = 1;
          starts.push_back(cyc);
        end
      end else begin
        cap[pos] = tx;
        pos++;
        if (pos == 41) begin
          mon_active = 1'b0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL frame_unexpected: observed %0h expected no frame", cap);
          end else begin
            mon_byte = exp_q.pop_front();
            chk("frame", 64'(cap), 64'(frame_bits(mon_byte)));
            $display("frame: byte %02h line %011h", mon_byte, cap);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d,
                       input bit expect_push);
    bus.MemWrite  = mw;
    bus.DataAdr   = a;
    bus.WriteData = d;
    if (expect_push) exp_q.push_back(d[7:0]);
    tick();
    $display("store: mw=%0d adr=%08h data=%08h", mw, a, d);
    bus.MemWrite  = MW_NONE;
    bus.DataAdr   = STA;
    bus.WriteData = 32'h0;
  endtask

  task automatic status_chk(input string tag, input logic [31:0] expv);
    bus.DataAdr = STA;
    #1;
    chk(tag, 64'(bus.ReadData), 64'(expv));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_active) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  int s0;

  initial begin
    bus.MemWrite  = MW_NONE;
    bus.DataAdr   = 32'h0;
    bus.WriteData = 32'h0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_tx", 64'(tx), 64'(1));
    status_chk("reset_status", 32'h0);
    rst = 1'b0;
    tick();

    // Single byte: start bit appears one edge after the push edge.
    store(MW_W, TXA, 32'hDEAD_BE41, 1'b1);
    status_chk("single_count", 32'h0000_0102);
    chk("single_tx_before", 64'(tx), 64'(1));
    tick();
    chk("single_tx_fall", 64'(tx), 64'(0));
    status_chk("single_popped", 32'h0000_0002);
    wait_idle("single_drain", 200);
    status_chk("single_idle", 32'h0);

    // Back-to-back byte stores; upper data bits must be discarded.
    s0 = starts.size();
    store(MW_B, TXA, 32'hFFFF_FF55, 1'b1);
    store(MW_B, TXA, 32'h1234_56AA, 1'b1);
    store(MW_B, TXA, 32'h0000_000F, 1'b1);
    status_chk("b2b_count", 32'h0000_0202);
    wait_idle("b2b_drain", 400);
    chk("b2b_frames", 64'(starts.size() - s0), 64'(3));
    if (starts.size() - s0 == 3) begin
      chk("b2b_gap1", 64'(starts[s0+1] - starts[s0]), 64'(41));
      chk("b2b_gap2", 64'(starts[s0+2] - starts[s0+1]), 64'(41));
    end
    status_chk("b2b_idle", 32'h0);

    // Overflow: six stores while the first frame occupies the line.
    store(MW_W, TXA, 32'h0000_0030, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) store(MW_B, TXA, 32'h31 + 32'(i), (i < 4));
    status_chk("ovf_status", 32'h0000_0407);
    store(MW_H, STA, 32'h0000_FFFF, 1'b0);
    status_chk("ovf_cleared", 32'h0000_0403);
    wait_idle("ovf_drain", 600);
    status_chk("ovf_idle", 32'h0);

    // Full FIFO with a push landing on the IDLE pop edge.
    store(MW_W, TXA, 32'h0000_0060, 1'b1);
    for (int i = 1; i <= 4; i++) store(MW_B, TXA, 32'h60 + 32'(i), 1'b1);
    status_chk("fullpop_full", 32'h0000_0403);
    repeat (37) tick();
    status_chk("fullpop_before", 32'h0000_0403);
    store(MW_B, TXA, 32'h0000_0065, 1'b1);
    status_chk("fullpop_after", 32'h0000_0403);
    wait_idle("fullpop_drain", 800);
    status_chk("fullpop_idle", 32'h0);

    // Address decode.
    s0 = starts.size();
    bus.MemWrite  = MW_W;
    bus.DataAdr   = 32'h1000_0008;
    bus.WriteData = 32'h0000_0077;
    #1;
    chk("decode_miss_hit", 64'(bus.hit), 64'(0));
    chk("decode_miss_rd", 64'(bus.ReadData), 64'(0));
    tick();
    $display("store: mw=3 adr=10000008 data=00000077");
    bus.MemWrite = MW_NONE;
    bus.DataAdr  = TXA;
    #1;
    chk("decode_tx_hit", 64'(bus.hit), 64'(1));
    chk("decode_tx_rd", 64'(bus.ReadData), 64'(0));
    tick();
    status_chk("decode_idle_rd", 32'h0);
    chk("decode_stat_hit", 64'(bus.hit), 64'(1));
    repeat (20) tick();
    chk("decode_no_frame", 64'(starts.size() - s0), 64'(0));

    // Reset during DATA bit 3 with two bytes still queued.
    store(MW_W, TXA, 32'h0000_0071, 1'b1);
    store(MW_W, TXA, 32'h0000_0072, 1'b1);
    store(MW_W, TXA, 32'h0000_0073, 1'b1);
    status_chk("rst_queued", 32'h0000_0202);
    repeat (15) tick();
    chk("rst_bit3_level", 64'(tx), 64'(0));
    rst = 1'b1;
    tick();
    chk("rst_tx_high", 64'(tx), 64'(1));
    status_chk("rst_status", 32'h0);
    rst = 1'b0;
    exp_q.delete();
    s0 = starts.size();
    repeat (100) tick();
    chk("rst_no_frames", 64'(starts.size() - s0), 64'(0));
    chk("rst_tx_idle", 64'(tx), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
